// File: rtl/cu_read_command_arbiter_if.sv
// Command/status types and the bundled bus between CU job-control requesters,
// the read-command arbiter and the AFU read command buffer.
package cu_arb_pkg;
    typedef struct packed {
        logic [7:0]  cu_id;
        logic [11:0] real_size;
    } CommandMeta;

    typedef struct packed {
        logic        valid;
        logic [63:0] address;
        logic [11:0] size;
        CommandMeta  cmd;
    } CommandBufferLine;

    // empty sits in the LSB so an idle FIFO reads back as 4'b0001
    typedef struct packed {
        logic valid;
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;
endpackage

interface cu_read_command_arbiter_if #(parameter int NUM_REQ = 4);
    localparam int IW = $clog2(NUM_REQ);

    logic                                       enabled;
    cu_arb_pkg::CommandBufferLine [NUM_REQ-1:0] command_in;
    cu_arb_pkg::BufferStatus                    command_buffer_status;
    cu_arb_pkg::CommandBufferLine               command_out;
    cu_arb_pkg::BufferStatus      [NUM_REQ-1:0] req_buffer_status;
    logic                         [IW-1:0]      grant_id;
    logic                         [NUM_REQ-1:0] overflow;

    modport master (
        output enabled, command_in, command_buffer_status,
        input  command_out, req_buffer_status, grant_id, overflow
    );
    modport slave (
        input  enabled, command_in, command_buffer_status,
        output command_out, req_buffer_status, grant_id, overflow
    );
endinterface

// File: rtl/cu_read_command_arbiter.sv
// Per-requester command FIFOs drained round-robin onto one CU read-command
// channel, throttled by the downstream command buffer's almost-full flag.
module cu_rd_cmd_fifo import cu_arb_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  CommandBufferLine din,
    output CommandBufferLine head,
    output BufferStatus      status,
    output logic             last_one,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ALFULL = (AW+1)'(DEPTH - 2);

    CommandBufferLine mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, wr_en;

    assign full  = (count == CNT_FULL);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + (AW+1)'(1);
            else if (!wr_en && pop) count <= count - (AW+1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign head          = mem[rd_ptr];
    assign last_one      = (count == (AW+1)'(1));
    assign status.valid  = (count != '0);
    assign status.alfull = (count >= CNT_ALFULL);
    assign status.full   = full;
    assign status.empty  = (count == '0);
endmodule

module cu_read_command_arbiter import cu_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic                      clock,
    input logic                      rstn,
    cu_read_command_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ARB_RESET, ARB_IDLE, ARB_GRANT, ARB_STALL} arb_state_t;

    arb_state_t                     state, state_nx;
    CommandBufferLine [NUM_REQ-1:0] in_q, head;
    BufferStatus      [NUM_REQ-1:0] fifo_status;
    logic             [NUM_REQ-1:0] push, pop_vec, nonempty, last_one, remain, ovf;
    logic                           alfull_q, pop_en, found;
    logic                           any_nonempty, any_push, any_remain;
    logic [IW-1:0]                  rr_ptr, grant, rr_next, gid_q;
    CommandBufferLine               out_q;

    // only .alfull of the downstream status steers the arbiter
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            in_q     <= '0;
            alfull_q <= 1'b0;
        end else if (bus.enabled) begin
            in_q     <= bus.command_in;
            alfull_q <= bus.command_buffer_status.alfull;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign push[i]     = bus.enabled & in_q[i].valid;
        assign pop_vec[i]  = pop_en & (grant == IW'(i));
        assign nonempty[i] = ~fifo_status[i].empty;
        assign remain[i]   = push[i] | (nonempty[i] & ~(pop_vec[i] & last_one[i]));

        cu_rd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock    (clock),
            .rstn     (rstn),
            .push     (push[i]),
            .pop      (pop_vec[i]),
            .din      (in_q[i]),
            .head     (head[i]),
            .status   (fifo_status[i]),
            .last_one (last_one[i]),
            .overflow (ovf[i])
        );
    end

    assign any_nonempty = |nonempty;
    assign any_push     = |push;
    assign any_remain   = |remain;

    // first non-empty port at or after rr_ptr, wrapping
    always_comb begin : p_arb
        int j;
        j     = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && nonempty[j]) begin
                found = 1'b1;
                grant = IW'(j);
            end
        end
    end

    assign rr_next = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)             state <= ARB_RESET;
        else if (bus.enabled)  state <= state_nx;
    end

    // pending pushes count as work so an idle arbiter reaches GRANT in time
    always_comb begin
        state_nx = state;
        case (state)
            ARB_RESET: state_nx = ARB_IDLE;
            ARB_IDLE:  if ((any_nonempty || any_push) && !alfull_q) state_nx = ARB_GRANT;
            ARB_GRANT: if (alfull_q) state_nx = ARB_STALL;
                       else if (!any_remain) state_nx = ARB_IDLE;
            ARB_STALL: if (!alfull_q) state_nx = (any_nonempty || any_push) ? ARB_GRANT : ARB_IDLE;
            default:   state_nx = ARB_RESET;
        endcase
    end

    always_comb begin
        pop_en = bus.enabled && (state == ARB_GRANT) && !alfull_q && any_nonempty;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            out_q  <= '0;
            gid_q  <= '0;
            rr_ptr <= '0;
        end else if (bus.enabled) begin
            out_q <= pop_en ? head[grant] : '0;
            if (pop_en) begin
                gid_q  <= grant;
                rr_ptr <= rr_next;
            end
        end
    end

    assign bus.command_out       = out_q;
    assign bus.grant_id          = gid_q;
    assign bus.req_buffer_status = fifo_status;
    assign bus.overflow          = ovf;
endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed bench for the CU read-command arbiter: stimulus queues expected
// issues, a negedge monitor pops and compares every issued command.
module tb_cu_read_command_arbiter;
    import cu_arb_pkg::*;

    typedef struct {
        logic [1:0]       gid;
        CommandBufferLine cmd;
    } exp_t;

    logic clock, rstn;
    cu_read_command_arbiter_if #(.NUM_REQ(4)) bus_if ();

    cu_read_command_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(8)) dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t             exp_q[$];
    int               tests = 0, fails = 0, issued = 0, cyc = 0, last_valid_cyc = 0;
    logic             en_prev = 1'b0;
    CommandBufferLine last_cmd = '0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cmd(input string name, input CommandBufferLine act, input CommandBufferLine exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got v%b addr %h size %h cu %0d rs %h, expected v%b addr %h size %h cu %0d rs %h",
                     name, act.valid, act.address, act.size, act.cmd.cu_id, act.cmd.real_size,
                     exp.valid, exp.address, exp.size, exp.cmd.cu_id, exp.cmd.real_size);
        end
    endtask

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        en_prev <= bus_if.enabled & rstn;
    end

    always @(negedge clock) begin : mon
        exp_t e;
        if (rstn && en_prev && bus_if.command_out.valid) begin
            issued++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got command from port %0d, expected none", bus_if.grant_id);
            end else begin
                e = exp_q.pop_front();
                check_cmd("issue_cmd", bus_if.command_out, e.cmd);
                check("issue_gid", int'(bus_if.grant_id), int'(e.gid));
                last_cmd = e.cmd;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic CommandBufferLine mk(input int p, input int k);
        CommandBufferLine c;
        c.valid          = 1'b1;
        c.address        = 64'h1000_0000 * 64'(p + 1) + 64'(k * 64);
        c.size           = 12'(64 + k);
        c.cmd.cu_id      = 8'(p);
        c.cmd.real_size  = 12'(k + 1);
        return c;
    endfunction

    task automatic expect_cmd(input int p, input CommandBufferLine c);
        exp_t e;
        e.gid = 2'(p);
        e.cmd = c;
        exp_q.push_back(e);
    endtask

    task automatic push_one(input int p, input CommandBufferLine c, input bit exp);
        bus_if.command_in    = '0;
        bus_if.command_in[p] = c;
        if (exp) expect_cmd(p, c);
        tick();
        bus_if.command_in = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick(3);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string name);
        check_cmd({name, "_cmd_out"}, bus_if.command_out, '0);
        check({name, "_grant_id"}, int'(bus_if.grant_id), 0);
        check({name, "_overflow"}, int'(bus_if.overflow), 0);
        for (int p = 0; p < 4; p++)
            check({name, "_status"}, int'(bus_if.req_buffer_status[p]), 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k0, c0, c1, cf;
        CommandBufferLine c;
        rstn                  = 1'b0;
        bus_if.enabled        = 1'b1;
        bus_if.command_in     = '0;
        bus_if.command_buffer_status = '0;
        tick(2);
        check_reset_state("reset");
        rstn = 1'b1;
        tick(3);

        // 1: single command, 3-cycle latency
        c = '0;
        c.valid = 1'b1; c.address = 64'h1000; c.size = 12'h080;
        c.cmd.cu_id = 8'd2; c.cmd.real_size = 12'h080;
        c0 = issued;
        k0 = cyc;
        push_one(2, c, 1'b1);
        wait_drain("t1_drain", 20);
        check("t1_latency", last_valid_cyc, k0 + 3);
        check("t1_count", issued - c0, 1);

        // 2: four ports x three commands, strict rotation without gaps
        rstn = 1'b0; exp_q.delete(); tick(2); rstn = 1'b1; tick(3);
        c0 = issued;
        k0 = cyc;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) begin
                bus_if.command_in[p] = mk(p, k);
                expect_cmd(p, mk(p, k));
            end
            tick();
        end
        bus_if.command_in = '0;
        wait_drain("t2_drain", 40);
        check("t2_count", issued - c0, 12);
        check("t2_last_cycle", last_valid_cyc, k0 + 14);

        // 3: downstream alfull rises mid-drain
        c0 = issued;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) bus_if.command_buffer_status.alfull = 1'b1;
            push_one(3, mk(3, k), 1'b1);
        end
        tick(4);
        c1 = issued;
        check("t3_le2_after_alfull", int'((c1 - c0) <= 2), 1);
        tick(8);
        check("t3_stalled", issued - c1, 0);
        bus_if.command_buffer_status.alfull = 1'b0;
        wait_drain("t3_drain", 40);
        check("t3_count", issued - c0, 6);

        // 4: fill port 1 past capacity while throttled
        bus_if.command_buffer_status.alfull = 1'b1;
        tick(3);
        c0 = issued;
        for (int k = 0; k < 5; k++) push_one(1, mk(1, k), 1'b1);
        tick(3);
        check("t4_alfull_at5", int'(bus_if.req_buffer_status[1].alfull), 0);
        check("t4_valid_at5", int'(bus_if.req_buffer_status[1].valid), 1);
        push_one(1, mk(1, 5), 1'b1);
        tick(3);
        check("t4_alfull_at6", int'(bus_if.req_buffer_status[1].alfull), 1);
        check("t4_full_at6", int'(bus_if.req_buffer_status[1].full), 0);
        for (int k = 6; k < 8; k++) push_one(1, mk(1, k), 1'b1);
        tick(3);
        check("t4_full_at8", int'(bus_if.req_buffer_status[1].full), 1);
        check("t4_no_ovf_at8", int'(bus_if.overflow), 0);
        push_one(1, mk(1, 8), 1'b0);
        tick(3);
        check("t4_overflow", int'(bus_if.overflow), 2);
        check("t4_none_issued", issued - c0, 0);
        bus_if.command_buffer_status.alfull = 1'b0;
        wait_drain("t4_drain", 40);
        check("t4_count", issued - c0, 8);
        check("t4_status_empty", int'(bus_if.req_buffer_status[1]), 1);
        check("t4_overflow_sticky", int'(bus_if.overflow), 2);

        // 5: freeze mid-drain
        c0 = issued;
        for (int k = 0; k < 6; k++) push_one(0, mk(0, k), 1'b1);
        bus_if.enabled = 1'b0;
        tick();
        cf = issued;
        for (int i = 0; i < 5; i++) begin
            check_cmd("t5_frozen_out", bus_if.command_out, last_cmd);
            check("t5_frozen_gid", int'(bus_if.grant_id), 0);
            tick();
        end
        check("t5_no_issue_frozen", issued - cf, 0);
        bus_if.enabled = 1'b1;
        wait_drain("t5_drain", 40);
        check("t5_count", issued - c0, 6);

        // 6: reset with queued commands
        bus_if.command_buffer_status.alfull = 1'b1;
        tick(3);
        for (int k = 0; k < 5; k++) push_one(2, mk(2, k), 1'b0);
        tick(3);
        check("t6_queued", int'(bus_if.req_buffer_status[2].valid), 1);
        rstn = 1'b0;
        exp_q.delete();
        bus_if.command_buffer_status.alfull = 1'b0;
        #1;
        check_reset_state("t6_reset");
        tick(2);
        rstn = 1'b1;
        tick(3);
        c0 = issued;
        for (int p = 3; p >= 0; p--) bus_if.command_in[p] = mk(p, 9);
        for (int p = 0; p < 4; p++) expect_cmd(p, mk(p, 9));
        tick();
        bus_if.command_in = '0;
        wait_drain("t6_drain", 30);
        check("t6_count", issued - c0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
